// File: rtl/daub6_window_feeder.sv
// Sliding 10-sample window feeder producing 16-word decimate-by-2 polyphase windows.
// Optional build macro DAUB6_WIN_ZEROFILL_EN: start in RUN with a zero-padded first window.
module daub6_window_feeder #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] win0,
    output logic signed [DATA_WIDTH-1:0] win1,
    output logic signed [DATA_WIDTH-1:0] win2,
    output logic signed [DATA_WIDTH-1:0] win3,
    output logic signed [DATA_WIDTH-1:0] win4,
    output logic signed [DATA_WIDTH-1:0] win5,
    output logic signed [DATA_WIDTH-1:0] win6,
    output logic signed [DATA_WIDTH-1:0] win7,
    output logic signed [DATA_WIDTH-1:0] win8,
    output logic signed [DATA_WIDTH-1:0] win9,
    output logic signed [DATA_WIDTH-1:0] win10,
    output logic signed [DATA_WIDTH-1:0] win11,
    output logic signed [DATA_WIDTH-1:0] win12,
    output logic signed [DATA_WIDTH-1:0] win13,
    output logic signed [DATA_WIDTH-1:0] win14,
    output logic signed [DATA_WIDTH-1:0] win15,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic                         fsm_state
);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

`ifdef DAUB6_WIN_ZEROFILL_EN
    localparam state_t RESET_STATE = RUN;
`else
    localparam state_t RESET_STATE = FILL;
`endif

    // Handshakes: a sample moves when in_valid && in_ready, a window moves when
    // win_valid && win_ready; the only stall is the sample that would complete a window.
    state_t                       state;
    state_t                       state_nx;
    logic   [3:0]                 cnt;
    logic   [3:0]                 cnt_nx;
    logic                         completes;
    logic                         accept;
    logic                         capture;
    logic signed [DATA_WIDTH-1:0] w       [10];
    logic signed [DATA_WIDTH-1:0] shifted [10];
    logic signed [DATA_WIDTH-1:0] win_q   [16];

    always_comb begin
        completes = (state == FILL) ? (cnt == 4'd9) : (cnt == 4'd7);
        in_ready  = !(completes && win_valid && !win_ready);
        accept    = in_valid && in_ready;
        capture   = accept && completes;
        state_nx  = state;
        cnt_nx    = cnt;
        if (accept) begin
            if (completes) begin
                state_nx = RUN;
                cnt_nx   = 4'd0;
            end else begin
                cnt_nx = cnt + 4'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            shifted[i] = w[i+1];
        end
        shifted[9] = in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_STATE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) begin
                w[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
            win_valid <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < 10; i++) begin
                    w[i] <= shifted[i];
                end
            end
            // Lane k starts at w[2k]; the last two samples carry into the next window.
            if (capture) begin
                for (int k = 0; k < 4; k++) begin
                    for (int j = 0; j < 4; j++) begin
                        win_q[4*k+j] <= shifted[2*k+j];
                    end
                end
            end
            win_valid <= capture || (win_valid && !win_ready);
        end
    end

    assign win0      = win_q[0];
    assign win1      = win_q[1];
    assign win2      = win_q[2];
    assign win3      = win_q[3];
    assign win4      = win_q[4];
    assign win5      = win_q[5];
    assign win6      = win_q[6];
    assign win7      = win_q[7];
    assign win8      = win_q[8];
    assign win9      = win_q[9];
    assign win10     = win_q[10];
    assign win11     = win_q[11];
    assign win12     = win_q[12];
    assign win13     = win_q[13];
    assign win14     = win_q[14];
    assign win15     = win_q[15];
    assign fsm_state = state;

endmodule

// File: tb/tb_daub6_window_feeder.sv
// Randomised scoreboard bench for daub6_window_feeder: a sample-list model predicts windows and in_ready.
// Honours DAUB6_WIN_ZEROFILL_EN the same way as the design.
module tb_daub6_window_feeder;

    localparam int W = 16;
`ifdef DAUB6_WIN_ZEROFILL_EN
    localparam int PAD = 2;
    localparam logic EXP_RST_STATE = 1'b1;
`else
    localparam int PAD = 0;
    localparam logic EXP_RST_STATE = 1'b0;
`endif

    logic clk;
    logic rst;
    logic signed [W-1:0] in_data;
    logic in_valid;
    logic in_ready;
    logic signed [W-1:0] win0, win1, win2, win3, win4, win5, win6, win7;
    logic signed [W-1:0] win8, win9, win10, win11, win12, win13, win14, win15;
    logic win_valid;
    logic win_ready;
    logic fsm_state;

    int total = 0;
    int bad = 0;
    logic rmode = 1'b0;

    logic [W-1:0]    smp[$];
    logic [16*W-1:0] exp_q[$];

    daub6_window_feeder #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .win0(win0), .win1(win1), .win2(win2), .win3(win3),
        .win4(win4), .win5(win5), .win6(win6), .win7(win7),
        .win8(win8), .win9(win9), .win10(win10), .win11(win11),
        .win12(win12), .win13(win13), .win14(win14), .win15(win15),
        .win_valid(win_valid), .win_ready(win_ready), .fsm_state(fsm_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [16*W-1:0] pack_win();
        return {win15, win14, win13, win12, win11, win10, win9, win8,
                win7, win6, win5, win4, win3, win2, win1, win0};
    endfunction

    task automatic chk(input string nm, input logic [16*W-1:0] got, input logic [16*W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // reference model: window n covers samples (pad included) [8n .. 8n+9]
    function automatic logic next_completes();
        int t;
        t = smp.size() + 1;
        return (t >= 10) && (((t - 10) % 8) == 0);
    endfunction

    function automatic void model_push(input logic [W-1:0] d);
        int t;
        logic [16*W-1:0] win;
        smp.push_back(d);
        t = smp.size();
        if (t >= 10 && ((t - 10) % 8) == 0) begin
            win = '0;
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 4; j++) begin
                    win[(4*k+j)*W +: W] = smp[t - 10 + 2*k + j];
                end
            end
            exp_q.push_back(win);
        end
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        logic exp_valid;
        logic exp_ready;
        if (!rst) begin
            exp_valid = (exp_q.size() > 0);
            exp_ready = !(next_completes() && exp_valid && !win_ready);
            chk("win_valid", {255'd0, win_valid}, {255'd0, exp_valid});
            chk("in_ready", {255'd0, in_ready}, {255'd0, exp_ready});
            if (exp_valid) begin
                chk("window", pack_win(), exp_q[0]);
                if (win_ready) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) model_push(in_data);
        end
    end

    // random consumer
    always @(posedge clk) begin
        if (rmode) begin
            #1 win_ready = ($urandom_range(0, 3) == 0);
        end
    end

    // driver tasks: each returns at 1 time unit after a rising edge
    task automatic send(input logic [W-1:0] d);
        int n;
        logic acc;
        n = 0;
        in_data = d;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: sample %h not accepted after %0d cycles", d, n);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_window", pack_win(), '0);
        chk("rst_win_valid", {255'd0, win_valid}, '0);
        chk("rst_state", {255'd0, fsm_state}, {255'd0, EXP_RST_STATE});
        smp.delete();
        exp_q.delete();
        repeat (PAD) smp.push_back('0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {255'd0, in_ready}, {255'd0, 1'b1});
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        win_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // basic fill and continuation with the consumer always ready
        for (int i = 1; i <= 18; i++) send(W'(i));
        idle(3);

        // backpressure: window 1 held while 11..17 fill, 18 stalls
        do_reset();
        for (int i = 1; i <= 10; i++) send(W'(i));
        win_ready = 1'b0;
        for (int i = 11; i <= 17; i++) send(W'(i));
        in_data = W'(18);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", {255'd0, in_ready}, '0);
            @(posedge clk);
            #1;
        end
        win_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        win_ready = 1'b0;
        idle(2);
        win_ready = 1'b1;
        idle(2);

        // extreme values
        do_reset();
        send(16'h8000);
        send(16'h7fff);
        send(16'hffff);
        for (int i = 0; i < 13; i++) send(16'h8000 + W'(i * 4099));
        idle(2);

        // reset in the middle of a window
        do_reset();
        for (int i = 0; i < 10 - PAD; i++) send(W'(100 + i));
        for (int i = 0; i < 5; i++) send(W'(200 + i));
        do_reset();
        for (int i = 0; i < 10 - PAD; i++) send(W'(300 + i));
        idle(2);

        // randomised traffic with a random consumer
        rmode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(W'($urandom_range(0, 65535)));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        rmode = 1'b0;
        #1 win_ready = 1'b1;

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            idle(1);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d windows never presented, expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/daub6_window_feeder.md
# daub6_window_feeder

Upstream feeder for the Daub-6 Method 1 combinational filter block. It accepts a serial stream of signed samples over a valid/ready handshake and keeps a 10-sample sliding window. For every 8 new samples it presents one registered 16-word window: four lanes of 4 taps each, with a stride of 2 samples between lanes (decimate-by-2 polyphase layout). The consumer is the 16-input, 4-output coefficient block, which sits directly downstream.

## Interface
- DATA_WIDTH, 16, sample and window word width (signed)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_data  input  DATA_WIDTH  signed input sample
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- win0..win15  output  DATA_WIDTH each  registered window words, feeding the downstream in0..in15
- win_valid  output  1  win0..win15 hold a complete window
- win_ready  input  1  downstream consumes the window this cycle

## Operation
- Sample transfer occurs when in_valid && in_ready. Window transfer occurs when win_valid && win_ready.
- Shift register w[0..9]: w[0] oldest, w[9] newest. Each accepted sample shifts in at w[9].
- Window mapping: win[4k+j] = w[2k+j] for lane k = 0..3 and tap j = 0..3.
- After a capture, w[8] and w[9] become the first two samples of the next window, so lane stride stays 2 across window boundaries.
- FSM states:
  - FILL: cnt counts accepted samples 0..9. The 10th accepted sample captures the window and moves to RUN with cnt = 0.
  - RUN: cnt counts 0..7. The 8th accepted sample captures the window and sets cnt = 0.
- Capture loads win0..15 from the post-shift window and sets win_valid.
- in_ready is low only when both hold:
  - the next sample would complete a window, and
  - win_valid && !win_ready.
- Otherwise in_ready = 1, so the shift register keeps filling while an older window waits for the consumer.
- Simultaneous events:
  - Window transfer plus capture in the same cycle: win_valid stays 1 and the new window is loaded.
  - Window transfer with no capture: win_valid clears.
- Arithmetic: none. Samples pass through bit-exact with no width change.
- Reset (asynchronous, at any time, including mid-window or with win_valid pending):
  - state = FILL, cnt = 0, w[*] = 0
  - win0..15 = 0, win_valid = 0
  - partial windows are discarded
- in_ready is 1 combinationally once rst deasserts.

## Timing
- Window latency: win_valid rises on the clock edge that accepts the completing sample, and is visible the following cycle.
- Window contents are stable while win_valid && !win_ready.
- Sustained throughput is 1 sample/cycle as long as win_ready is high in at least 1 of every 8 cycles.
- Under backpressure the only stall point is the completing sample. Stall duration equals the time win_valid waits for win_ready.
- No combinational path from in_valid to win_valid. in_ready depends combinationally on win_ready.

## Configuration
- DAUB6_WIN_ZEROFILL_EN defined:
  - Reset places the FSM directly in RUN with w[*] = 0.
  - The first window is emitted after 8 samples. Its w[0] and w[1] are zero (zero-padded start).
- Not defined: the FILL state is used, and the first window requires 10 samples.
- All other behaviour is identical in both builds.

## Test plan
- Basic fill (macro off), win_ready = 1, feed samples 1..10 back-to-back:
  - win_valid = 1 for exactly one cycle, one cycle after sample 10 is accepted
  - win0..3 = 1,2,3,4; win4..7 = 3,4,5,6; win8..11 = 5,6,7,8; win12..15 = 7,8,9,10
- Continue with 11..18:
  - second window win0..3 = 9,10,11,12 and win12..15 = 15,16,17,18
  - in_ready stays 1 throughout
- Backpressure: win_ready = 0 after the first window, feed 11..18:
  - 11..17 are accepted
  - in_ready = 0 while 18 is presented, and window 1 stays unchanged
  - raising win_ready for one cycle accepts 18 and transfers window 1 in the same cycle
  - the next cycle shows window 2 with win_valid = 1
- Negative and extreme values: feed -32768, 32767, -1:
  - values appear bit-exact at their mapped window positions, with no sign change
- Reset mid-window: after 5 samples of RUN, pulse rst asynchronously (between edges):
  - all outputs read 0 immediately and state returns to FILL
  - 10 new samples are then required before the next window
- Macro on: feed 1..8:
  - win0..3 = 0,0,1,2 and win12..15 = 5,6,7,8, emitted after the 8th sample
